// File: rtl/color_freq_decoder_if.sv
// Colour sensor / decoder signal bundle: square wave in, filter select and latched results out.
// master = the decoder, slave = the sensor/Core side.
interface color_freq_decoder_if #(
  parameter int CNT_W = 16
);
  logic             sq_in;
  logic [1:0]       filter_sel;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] clear_cnt;
  logic [1:0]       color;
  logic             valid;

  modport master (
    input  sq_in,
    output filter_sel, red_cnt, green_cnt, blue_cnt, clear_cnt, color, valid
  );

  modport slave (
    output sq_in,
    input  filter_sel, red_cnt, green_cnt, blue_cnt, clear_cnt, color, valid
  );
endinterface

// File: rtl/color_freq_decoder.sv
// Colour sensor front end: steps the S2/S3 filter through R, G, B (and C with COLOR_DEC_CLEAR_EN),
// counts square-wave edges per gate window, then latches counts and a colour class with a valid strobe.
module color_freq_decoder #(
  parameter int GATE_CYCLES   = 500000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  color_freq_decoder_if.master bus
);

  typedef enum logic [1:0] {SETTLE, GATE, DECIDE} state_t;
  typedef enum logic [1:0] {CH_R, CH_G, CH_B, CH_C} chan_t;
  typedef enum logic [1:0] {NONE, RED, GREEN, BLUE} color_t;

`ifdef COLOR_DEC_CLEAR_EN
  localparam int    NCH     = 4;
  localparam chan_t LAST_CH = CH_C;
`else
  localparam int    NCH     = 3;
  localparam chan_t LAST_CH = CH_B;
`endif

  localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);

  state_t           state, state_nx;
  chan_t            ch, ch_nx;
  logic [TMR_W-1:0] timer;
  logic             settle_done, gate_done;

  logic             s0, s1, s2, rise;
  logic [CNT_W-1:0] edge_cnt, cnt_inc;
  logic [CNT_W-1:0] shadow [NCH];

  logic             gate_on, gate_last, decide;
  color_t           cls;
  logic [CNT_W-1:0] win_val, thr_val;

  assign settle_done = (timer == TMR_W'(SETTLE_CYCLES - 1));
  assign gate_done   = (timer == TMR_W'(GATE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      ch    <= CH_R;
      timer <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
      timer <= (state_nx != state) ? '0 : timer + TMR_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    unique case (state)
      SETTLE: if (settle_done) state_nx = GATE;
      GATE: begin
        if (gate_done) begin
          if (ch == LAST_CH) begin
            state_nx = DECIDE;
          end else begin
            state_nx = SETTLE;
            ch_nx    = chan_t'(ch + 2'd1);
          end
        end
      end
      DECIDE: begin
        state_nx = SETTLE;
        ch_nx    = CH_R;
      end
      default: begin
        state_nx = SETTLE;
        ch_nx    = CH_R;
      end
    endcase
  end

  // filter_sel follows the channel register, so it switches on the SETTLE entry cycle
  always_comb begin
    gate_on   = (state == GATE);
    gate_last = gate_on && gate_done;
    decide    = (state == DECIDE);
    unique case (ch)
      CH_R:    bus.filter_sel = 2'b00;
      CH_G:    bus.filter_sel = 2'b11;
      CH_B:    bus.filter_sel = 2'b01;
      default: bus.filter_sel = 2'b10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= bus.sq_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise    = s1 & ~s2;
  assign cnt_inc = (rise && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (state == SETTLE && state_nx == GATE) begin
      edge_cnt <= '0;
    end else if (gate_on) begin
      edge_cnt <= cnt_inc;
    end
  end

  // cnt_inc rather than edge_cnt so a rise on the final gate cycle is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) shadow[i] <= '0;
    end else if (gate_last) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch == chan_t'(i)) shadow[i] <= cnt_inc;
      end
    end
  end

  always_comb begin
    cls     = NONE;
    win_val = '0;
    if (shadow[0] > shadow[1] && shadow[0] > shadow[2]) begin
      cls     = RED;
      win_val = shadow[0];
    end else if (shadow[1] > shadow[0] && shadow[1] > shadow[2]) begin
      cls     = GREEN;
      win_val = shadow[1];
    end else if (shadow[2] > shadow[0] && shadow[2] > shadow[1]) begin
      cls     = BLUE;
      win_val = shadow[2];
    end
`ifdef COLOR_DEC_CLEAR_EN
    thr_val = shadow[3];
`else
    thr_val = win_val;
`endif
    if (thr_val < CNT_W'(MIN_COUNT)) cls = NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.red_cnt   <= '0;
      bus.green_cnt <= '0;
      bus.blue_cnt  <= '0;
      bus.color     <= '0;
      bus.valid     <= 1'b0;
    end else begin
      bus.valid <= decide;
      if (decide) begin
        bus.red_cnt   <= shadow[0];
        bus.green_cnt <= shadow[1];
        bus.blue_cnt  <= shadow[2];
        bus.color     <= cls;
      end
    end
  end

`ifdef COLOR_DEC_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.clear_cnt <= '0;
    end else if (decide) begin
      bus.clear_cnt <= shadow[3];
    end
  end
`else
  assign bus.clear_cnt = '0;
`endif

endmodule

// File: tb/tb_color_freq_decoder.sv
// Bench for color_freq_decoder: two instances (CNT_W=8 and CNT_W=4) share one square wave and are
// compared every cycle against a frame-schedule model built from the driven pin history.
module tb_color_freq_decoder;
  localparam int GC   = 100;
  localparam int SC   = 10;
  localparam int MINC = 5;
`ifdef COLOR_DEC_CLEAR_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int SLOT  = GC + SC;
  localparam int FRAME = NCH * SLOT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_freq_decoder_if #(.CNT_W(8)) bus8 ();
  color_freq_decoder_if #(.CNT_W(4)) bus4 ();

  color_freq_decoder #(.GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .CNT_W(8), .MIN_COUNT(MINC)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  color_freq_decoder #(.GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .CNT_W(4), .MIN_COUNT(MINC)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fv    = 0;
  int per [4];
  logic noise;
  logic h1, h2, h3;
  int cm [2];
  int sh [2][4];
  int ec [2][4];
  int ecol [2];
  logic ev;
  int mx [2] = '{255, 15};
  logic [1:0] fcode [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // kind: 0 settle, 1 gate, 2 decide; e counts clock edges from 1 after reset release
  function automatic void slot_of(input int e, output int kind, output int ch, output int go);
    int f, o;
    f = (e - 1) % FRAME;
    ch = 0; go = 0; kind = 2;
    if (f != FRAME - 1) begin
      ch = f / SLOT;
      o  = f % SLOT;
      kind = (o >= SC) ? 1 : 0;
      go = o - SC;
    end
  endfunction

  // pin level whose rise would be seen by the counter at edge e
  function automatic logic gen_q(input int e);
    int k, c, g;
    slot_of(e, k, c, g);
    if (k == 2) return 1'b0;
    if (k == 0) return noise & e[0];
    if (per[c] == 0) return 1'b0;
    return (g % per[c]) >= (per[c] / 2);
  endfunction

  function automatic int classify(input int r, input int g, input int b, input int c);
    int m, n, win, thr;
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    n = int'(r == m) + int'(g == m) + int'(b == m);
    if (n != 1) return 0;
    win = (r == m) ? 1 : (g == m) ? 2 : 3;
`ifdef COLOR_DEC_CLEAR_EN
    thr = c;
`else
    thr = m;
    if (c != 0) thr = m;
`endif
    if (thr < MINC) return 0;
    return win;
  endfunction

  task automatic drive_pin(input logic v);
    bus8.sq_in = v;
    bus4.sq_in = v;
  endtask

  task automatic tick();
    logic rise;
    int k, c, g, kn, cn, gn;
    @(posedge clk);
    cyc++;
    rise = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = bus8.sq_in;
    slot_of(cyc, k, c, g);
    ev = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (k == 1) begin
        cm[w] = ((g == 0) ? 0 : cm[w]) + int'(rise);
        if (cm[w] > mx[w]) cm[w] = mx[w];
        if (g == GC - 1) sh[w][c] = cm[w];
      end else if (k == 2) begin
        for (int i = 0; i < 4; i++) ec[w][i] = sh[w][i];
        ecol[w] = classify(sh[w][0], sh[w][1], sh[w][2], sh[w][3]);
        ev = 1'b1;
      end
    end
    slot_of(cyc + 1, kn, cn, gn);
    if (kn == 2) cn = NCH - 1;
    #1;
    check("valid8",  32'(bus8.valid),      32'(ev));
    check("filter8", 32'(bus8.filter_sel), 32'(fcode[cn]));
    check("red8",    32'(bus8.red_cnt),    32'(ec[0][0]));
    check("green8",  32'(bus8.green_cnt),  32'(ec[0][1]));
    check("blue8",   32'(bus8.blue_cnt),   32'(ec[0][2]));
    check("clear8",  32'(bus8.clear_cnt),  32'(ec[0][3]));
    check("color8",  32'(bus8.color),      32'(ecol[0]));
    check("valid4",  32'(bus4.valid),      32'(ev));
    check("filter4", 32'(bus4.filter_sel), 32'(fcode[cn]));
    check("red4",    32'(bus4.red_cnt),    32'(ec[1][0]));
    check("green4",  32'(bus4.green_cnt),  32'(ec[1][1]));
    check("blue4",   32'(bus4.blue_cnt),   32'(ec[1][2]));
    check("clear4",  32'(bus4.clear_cnt),  32'(ec[1][3]));
    check("color4",  32'(bus4.color),      32'(ecol[1]));
    if (bus8.valid === 1'b1 && fv == 0) fv = cyc;
    drive_pin(gen_q(cyc + 3));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive_pin(1'b0);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_valid8",  32'(bus8.valid),      32'(0));
      check("rst_filter8", 32'(bus8.filter_sel), 32'(0));
      check("rst_red8",    32'(bus8.red_cnt),    32'(0));
      check("rst_green8",  32'(bus8.green_cnt),  32'(0));
      check("rst_blue8",   32'(bus8.blue_cnt),   32'(0));
      check("rst_clear8",  32'(bus8.clear_cnt),  32'(0));
      check("rst_color8",  32'(bus8.color),      32'(0));
      check("rst_valid4",  32'(bus4.valid),      32'(0));
      check("rst_red4",    32'(bus4.red_cnt),    32'(0));
    end
    rst = 1'b0;
    cyc = 0; fv = 0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      cm[w] = 0; ecol[w] = 0;
      for (int i = 0; i < 4; i++) begin sh[w][i] = 0; ec[w][i] = 0; end
    end
    drive_pin(gen_q(3));
  endtask

  task automatic run_frame();
    do tick(); while (cyc % FRAME != 0);
  endtask

  task automatic set_cfg(input int r, input int g, input int b, input int c, input logic nz);
    per[0] = r; per[1] = g; per[2] = b; per[3] = c; noise = nz;
  endtask

  task automatic frame_const(input string tag, input int r, input int g, input int b, input int col);
    check({tag, "_red"},   32'(bus8.red_cnt),   32'(r));
    check({tag, "_green"}, 32'(bus8.green_cnt), 32'(g));
    check({tag, "_blue"},  32'(bus8.blue_cnt),  32'(b));
    check({tag, "_color"}, 32'(bus8.color),     32'(col));
  endtask

  initial begin
    set_cfg(0, 0, 0, 0, 1'b0);
    do_reset(3);

    run_frame();
    check("first_valid", 32'(fv), 32'(FRAME));
    frame_const("idle", 0, 0, 0, 0);

    set_cfg(4, 10, 10, 0, 1'b0);
    run_frame();
`ifdef COLOR_DEC_CLEAR_EN
    frame_const("red_dom", 25, 10, 10, 0);
`else
    frame_const("red_dom", 25, 10, 10, 1);
`endif

    set_cfg(8, 8, 8, 8, 1'b0);
    run_frame();
    frame_const("tie", 12, 12, 12, 0);

    set_cfg(0, 0, 50, 0, 1'b0);
    run_frame();
    frame_const("thresh", 0, 0, 2, 0);

    set_cfg(0, 0, 0, 0, 1'b1);
    run_frame();
    frame_const("settle_mask", 0, 0, 0, 0);

    set_cfg(2, 10, 8, 0, 1'b0);
    run_frame();
    check("sat_red8", 32'(bus8.red_cnt), 32'(50));
    check("sat_red4", 32'(bus4.red_cnt), 32'(15));

`ifdef COLOR_DEC_CLEAR_EN
    set_cfg(4, 10, 10, 4, 1'b0);
    run_frame();
    check("clear_cnt", 32'(bus8.clear_cnt), 32'(25));
    check("clear_color", 32'(bus8.color), 32'(1));
`endif

    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < 4; c++)
        per[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 40));
      noise = logic'($urandom_range(0, 1));
      run_frame();
    end

    set_cfg(4, 4, 4, 4, 1'b0);
    repeat (SLOT + SC + 50) tick();
    do_reset(3);
    set_cfg(4, 10, 10, 0, 1'b0);
    run_frame();
    check("valid_after_mid_rst", 32'(fv), 32'(FRAME));
    run_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
